// File: rtl/mfcc_feature_buffer.sv
// Ping-pong feature-matrix buffer between the MFCC accelerator stream and the classifier.
// The writer fills one bank while the reader holds the other, and words are dropped when no bank is free.
module mfcc_feature_buffer #(
    parameter int NUM_COEFFS = 13,
    parameter int NUM_FRAMES = 49,
    parameter int DATA_W     = 16,
    parameter int DEPTH      = NUM_COEFFS * NUM_FRAMES,
    parameter int AW         = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] mfcc_feature,
    input  logic              mfcc_valid,
    output logic              buf_ready,
    input  logic              rd_en,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              buf_release,
    output logic              overflow,
    input  logic              clr_overflow,
    output logic [7:0]        matrix_count
);

    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

    typedef enum logic [0:0] {WR_FILL = 1'b0, WR_WAIT = 1'b1} wr_state_t;
    typedef enum logic [0:0] {RD_IDLE = 1'b0, RD_HELD = 1'b1} rd_state_t;

    wr_state_t         wr_state_r, wr_state_n_s;
    rd_state_t         rd_state_r, rd_state_n_s;
    logic [AW-1:0]     wr_ptr_r, wr_ptr_n_s;
    logic              wr_bank_r, wr_bank_n_s;
    logic              rd_bank_r, rd_bank_n_s;
    logic              wr_en_s, drop_s, handover_s, rel_s;
    logic [7:0]        matrix_count_r;
    logic              overflow_r;
    logic [DATA_W-1:0] rd_data_r;
    logic              rd_valid_r;
    logic [DATA_W-1:0] bank_mem_r [2][DEPTH];

    assign rel_s = buf_release && (rd_state_r == RD_HELD);

    // Writer next-state: accept, complete a matrix, or drop while both banks are occupied
    always_comb begin
        wr_state_n_s = wr_state_r;
        wr_ptr_n_s   = wr_ptr_r;
        wr_bank_n_s  = wr_bank_r;
        rd_bank_n_s  = rd_bank_r;
        wr_en_s      = 1'b0;
        drop_s       = 1'b0;
        handover_s   = 1'b0;
        case (wr_state_r)
            WR_FILL: begin
                if (mfcc_valid) begin
                    wr_en_s = 1'b1;
                    if (wr_ptr_r == LAST_PTR) begin
                        // A release in the same cycle frees the reader before the handover
                        if ((rd_state_r == RD_IDLE) || rel_s) begin
                            handover_s = 1'b1;
                        end else begin
                            wr_state_n_s = WR_WAIT;
                        end
                    end else begin
                        wr_ptr_n_s = wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
                    end
                end else begin
                    wr_en_s = 1'b0;
                end
            end
            WR_WAIT: begin
                drop_s = mfcc_valid;
                if (rel_s) begin
                    handover_s   = 1'b1;
                    wr_state_n_s = WR_FILL;
                end else begin
                    wr_state_n_s = WR_WAIT;
                end
            end
            default: begin
                wr_state_n_s = WR_FILL;
            end
        endcase
        if (handover_s) begin
            rd_bank_n_s = wr_bank_r;
            wr_bank_n_s = ~wr_bank_r;
            wr_ptr_n_s  = {AW{1'b0}};
        end else begin
            rd_bank_n_s = rd_bank_r;
        end
    end

    // Reader next-state: a handover always wins over a release
    always_comb begin
        rd_state_n_s = rd_state_r;
        case (rd_state_r)
            RD_IDLE: begin
                if (handover_s) begin
                    rd_state_n_s = RD_HELD;
                end else begin
                    rd_state_n_s = RD_IDLE;
                end
            end
            RD_HELD: begin
                if (handover_s) begin
                    rd_state_n_s = RD_HELD;
                end else if (rel_s) begin
                    rd_state_n_s = RD_IDLE;
                end else begin
                    rd_state_n_s = RD_HELD;
                end
            end
            default: begin
                rd_state_n_s = RD_IDLE;
            end
        endcase
    end

    // Control state, handover counter and sticky overflow
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_state_r     <= WR_FILL;
            rd_state_r     <= RD_IDLE;
            wr_ptr_r       <= {AW{1'b0}};
            wr_bank_r      <= 1'b0;
            rd_bank_r      <= 1'b0;
            matrix_count_r <= 8'd0;
            overflow_r     <= 1'b0;
        end else begin
            wr_state_r     <= wr_state_n_s;
            rd_state_r     <= rd_state_n_s;
            wr_ptr_r       <= wr_ptr_n_s;
            wr_bank_r      <= wr_bank_n_s;
            rd_bank_r      <= rd_bank_n_s;
            matrix_count_r <= handover_s ? (matrix_count_r + 8'd1) : matrix_count_r;
            overflow_r     <= (overflow_r && !clr_overflow) || drop_s;
        end
    end

    // Bank storage is deliberately not reset
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            bank_mem_r[wr_bank_r][wr_ptr_r] <= mfcc_feature;
        end
    end

    // Registered read port; the bank selected before this edge is the one read
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data_r  <= {DATA_W{1'b0}};
            rd_valid_r <= 1'b0;
        end else begin
            rd_valid_r <= rd_en;
            if (rd_en) begin
                if ((rd_state_r == RD_HELD) && (rd_addr <= LAST_PTR)) begin
                    rd_data_r <= bank_mem_r[rd_bank_r][rd_addr];
                end else begin
                    rd_data_r <= {DATA_W{1'b0}};
                end
            end else begin
                rd_data_r <= rd_data_r;
            end
        end
    end

    assign buf_ready    = (rd_state_r == RD_HELD);
    assign rd_data      = rd_data_r;
    assign rd_valid     = rd_valid_r;
    assign overflow     = overflow_r;
    assign matrix_count = matrix_count_r;

endmodule

// File: tb/tb_mfcc_feature_buffer.sv
// Self-checking bench for mfcc_feature_buffer: directed scenarios plus randomized traffic
// compared cycle by cycle against a matrix-level reference model.
module tb_mfcc_feature_buffer;

    localparam int DEPTH = 637;

    logic        clk;
    logic        rst;
    logic [15:0] mfcc_feature;
    logic        mfcc_valid;
    logic        buf_ready;
    logic        rd_en;
    logic [9:0]  rd_addr;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic        buf_release;
    logic        overflow;
    logic        clr_overflow;
    logic [7:0]  matrix_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: the matrix being collected, one complete matrix waiting, and the held one
    logic [15:0] m_fill [DEPTH];
    logic [15:0] m_pend [DEPTH];
    logic [15:0] m_held_mem [DEPTH];
    int          m_fill_n;
    bit          m_waiting;
    bit          m_held;
    bit          m_ovf;
    int          m_count;

    mfcc_feature_buffer dut (
        .clk          (clk),
        .rst          (rst),
        .mfcc_feature (mfcc_feature),
        .mfcc_valid   (mfcc_valid),
        .buf_ready    (buf_ready),
        .rd_en        (rd_en),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .buf_release  (buf_release),
        .overflow     (overflow),
        .clr_overflow (clr_overflow),
        .matrix_count (matrix_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_fill_n  = 0;
        m_waiting = 1'b0;
        m_held    = 1'b0;
        m_ovf     = 1'b0;
        m_count   = 0;
    endtask

    // One clock cycle: drive inputs, advance the model, check every output after the edge
    task automatic step(input bit v, input logic [15:0] d, input bit re, input logic [9:0] a,
                        input bit rel, input bit clr);
        logic [15:0] exp_rd;
        bit          rel_eff;
        bit          handed;
        bit          drop;
        mfcc_feature = d;
        mfcc_valid   = v;
        rd_en        = re;
        rd_addr      = a;
        buf_release  = rel;
        clr_overflow = clr;
        exp_rd  = (m_held && (a < 10'(DEPTH))) ? m_held_mem[a] : 16'd0;
        rel_eff = rel && m_held;
        handed  = 1'b0;
        drop    = 1'b0;
        if (m_waiting) begin
            drop = v;
            if (rel_eff) begin
                m_held_mem = m_pend;
                m_waiting  = 1'b0;
                handed     = 1'b1;
            end
        end else if (v) begin
            m_fill[m_fill_n] = d;
            m_fill_n++;
            if (m_fill_n == DEPTH) begin
                m_fill_n = 0;
                if (!m_held || rel_eff) begin
                    m_held_mem = m_fill;
                    handed     = 1'b1;
                end else begin
                    m_pend    = m_fill;
                    m_waiting = 1'b1;
                end
            end
        end
        if (handed) begin
            m_held  = 1'b1;
            m_count = (m_count + 1) % 256;
        end else if (rel_eff) begin
            m_held = 1'b0;
        end
        m_ovf = (m_ovf && !clr) || drop;
        @(posedge clk);
        #1;
        check_val("buf_ready", buf_ready, m_held);
        check_val("overflow", overflow, m_ovf);
        check_val("matrix_count", matrix_count, m_count);
        check_val("rd_valid", rd_valid, re);
        if (re) check_val("rd_data", rd_data, exp_rd);
        mfcc_valid   = 1'b0;
        rd_en        = 1'b0;
        buf_release  = 1'b0;
        clr_overflow = 1'b0;
    endtask

    task automatic stream(input int n, input int base);
        for (int i = 0; i < n; i++) step(1'b1, 16'(base + i), 1'b0, 10'd0, 1'b0, 1'b0);
    endtask

    task automatic rd(input int a);
        step(1'b0, 16'd0, 1'b1, 10'(a), 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #2;
        check_val("rst_buf_ready", buf_ready, 1'b0);
        check_val("rst_rd_valid", rd_valid, 1'b0);
        check_val("rst_rd_data", rd_data, 16'd0);
        check_val("rst_overflow", overflow, 1'b0);
        check_val("rst_matrix_count", matrix_count, 8'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        mfcc_feature = 16'd0;
        mfcc_valid   = 1'b0;
        rd_en        = 1'b0;
        rd_addr      = 10'd0;
        buf_release  = 1'b0;
        clr_overflow = 1'b0;
        rst          = 1'b1;
        @(posedge clk);
        #1;
        do_reset();

        // First matrix, values equal to index
        stream(DEPTH, 0);
        check_val("m0_ready", buf_ready, 1'b1);
        rd(0);   check_val("m0_a0", rd_data, 16'd0);
        rd(13);  check_val("m0_a13", rd_data, 16'd13);
        rd(636); check_val("m0_a636", rd_data, 16'd636);
        check_val("m0_count", matrix_count, 8'd1);
        check_val("m0_ovf", overflow, 1'b0);

        // Second matrix fills while the first is held, then drops
        stream(DEPTH, 1000);
        stream(5, 5000);
        check_val("wait_ovf", overflow, 1'b1);
        step(1'b0, 16'd0, 1'b0, 10'd0, 1'b1, 1'b0);
        check_val("wait_rel_ready", buf_ready, 1'b1);
        rd(5); check_val("m1_a5", rd_data, 16'd1005);
        check_val("m1_count", matrix_count, 8'd2);

        // Clear overflow, then clear again with nothing dropped
        step(1'b0, 16'd0, 1'b0, 10'd0, 1'b0, 1'b1);
        check_val("clr_ovf", overflow, 1'b0);
        step(1'b0, 16'd0, 1'b0, 10'd0, 1'b0, 1'b1);
        check_val("clr_ovf_nodrop", overflow, 1'b0);

        // Last word coincident with release
        stream(DEPTH - 1, 3000);
        step(1'b1, 16'd3636, 1'b1, 10'd636, 1'b1, 1'b0);
        check_val("coinc_old_read", rd_data, 16'd1636);
        check_val("coinc_ready", buf_ready, 1'b1);
        rd(636); check_val("coinc_a636", rd_data, 16'd3636);
        check_val("coinc_count", matrix_count, 8'd3);
        rd(637); check_val("oob_data", rd_data, 16'd0);
        check_val("oob_valid", rd_valid, 1'b1);

        // Release to idle; reads return zero, release ignored
        step(1'b0, 16'd0, 1'b0, 10'd0, 1'b1, 1'b0);
        check_val("idle_ready", buf_ready, 1'b0);
        rd(5); check_val("idle_data", rd_data, 16'd0);
        step(1'b0, 16'd0, 1'b0, 10'd0, 1'b1, 1'b0);
        check_val("idle_rel_count", matrix_count, 8'd3);

        // Reset mid-fill discards the partial matrix
        stream(300, 7000);
        do_reset();
        stream(DEPTH, 2000);
        rd(0);   check_val("rst_m_a0", rd_data, 16'd2000);
        rd(299); check_val("rst_m_a299", rd_data, 16'd2299);

        // Clear coincident with a drop: set wins
        stream(DEPTH, 4000);
        step(1'b1, 16'd9, 1'b0, 10'd0, 1'b0, 1'b1);
        check_val("clr_vs_drop", overflow, 1'b1);
        step(1'b1, 16'd9, 1'b0, 10'd0, 1'b1, 1'b0);
        rd(1); check_val("m4_a1", rd_data, 16'd4001);

        // Randomized traffic
        for (int c = 0; c < 6000; c++) begin
            step(($urandom % 4) != 0, 16'($urandom), ($urandom % 2) == 1,
                 10'($urandom_range(0, 700)), ($urandom % 150) == 0, ($urandom % 80) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
